// File: rtl/mcu_bus_if_pkg.sv
// max51_bus_pkg: shared types and constants for the max51 MCU bus front-end.
// Holds the bus FSM state encoding, bus widths, default timing parameters
// and the idle levels that the synchroniser stages reset to.
package max51_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam int WR_SAMPLE_DLY_DEF = 8;
  localparam int RD_LAT_DEF        = 1;

  // Levels the bus shows when the MCU is not running a cycle.
  localparam logic              ALE_INACTIVE  = 1'b0;
  localparam logic              STB_INACTIVE  = 1'b1;
  localparam logic [DATA_W-1:0] DATA_INACTIVE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_WR_HOLD = 2'd2,
    ST_RD_ACT  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/mcu_bus_if_if.sv
// mcu_bus_if_if: bundles the 8051 pad signals and the internal register bus.
//   MCU side : mcu_ale, mcu_psen_n, mcu_wr_n, mcu_rd_n, mcu_p0_i, mcu_p2_i (to front-end)
//              mcu_p0_o, mcu_p0_oe (from front-end, P0 read drive)
//   Bus side : bus_addr, bus_wdata, bus_wr_stb, bus_rd_stb, bus_err (from front-end)
//              bus_rdata (to front-end, read return data)
// slave  = the front-end block; master = whatever drives the pads / answers reads.
interface mcu_bus_if_if;
  import max51_bus_pkg::*;

  logic              mcu_ale;
  logic              mcu_psen_n;
  logic              mcu_wr_n;
  logic              mcu_rd_n;
  logic [DATA_W-1:0] mcu_p0_i;
  logic [DATA_W-1:0] mcu_p2_i;
  logic [DATA_W-1:0] mcu_p0_o;
  logic              mcu_p0_oe;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr_stb;
  logic              bus_rd_stb;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport slave (
    input  mcu_ale, mcu_psen_n, mcu_wr_n, mcu_rd_n, mcu_p0_i, mcu_p2_i, bus_rdata,
    output mcu_p0_o, mcu_p0_oe, bus_addr, bus_wdata, bus_wr_stb, bus_rd_stb, bus_err
  );

  modport master (
    output mcu_ale, mcu_psen_n, mcu_wr_n, mcu_rd_n, mcu_p0_i, mcu_p2_i, bus_rdata,
    input  mcu_p0_o, mcu_p0_oe, bus_addr, bus_wdata, bus_wr_stb, bus_rd_stb, bus_err
  );

endinterface

// File: rtl/mcu_bus_if_sync_edge.sv
// sync_edge: two-flop synchroniser plus one delay flop for edge detection.
//   clk_50  in  : system clock
//   reset   in  : synchronous, active-high; all stages load INIT
//   i_async in  : asynchronous pad level
//   o_level out : synchronised level (second stage)
//   o_rise  out : one-cycle pulse on synchronised 0->1
//   o_fall  out : one-cycle pulse on synchronised 1->0
module sync_edge #(
  parameter logic INIT = 1'b1
) (
  input  logic clk_50,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchroniser chain with a trailing delay stage for edge compare.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s1 <= INIT;
      r_s2 <= INIT;
      r_s3 <= INIT;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/mcu_bus_if.sv
// mcu_bus_if: max51 front-end for the asynchronous 8051 external bus.
//   clk_50 in : 50 MHz system clock
//   reset  in : synchronous, active-high
//   bus       : mcu_bus_if_if.slave (pads in/out, register-bus strobes, read data in)
// Latches the MOVX address on ALE fall, converts WR_n/RD_n cycles into single-cycle
// strobes, drives P0 during reads and pulses bus_err on aborted or conflicting cycles.
module mcu_bus_if
  import max51_bus_pkg::*;
#(
  parameter int WR_SAMPLE_DLY = WR_SAMPLE_DLY_DEF,
  parameter int RD_LAT        = RD_LAT_DEF
) (
  input  logic         clk_50,
  input  logic         reset,
  mcu_bus_if_if.slave  bus
);

  logic w_ale_lvl, w_ale_rise, w_ale_fall;
  logic w_psen_lvl, w_psen_rise, w_psen_fall;
  logic w_wr_lvl, w_wr_rise, w_wr_fall;
  logic w_rd_lvl, w_rd_rise, w_rd_fall;
  logic w_unused_edges;

  sync_edge #(.INIT(ALE_INACTIVE)) u_sync_ale (
    .clk_50(clk_50), .reset(reset), .i_async(bus.mcu_ale),
    .o_level(w_ale_lvl), .o_rise(w_ale_rise), .o_fall(w_ale_fall)
  );
  sync_edge #(.INIT(STB_INACTIVE)) u_sync_psen (
    .clk_50(clk_50), .reset(reset), .i_async(bus.mcu_psen_n),
    .o_level(w_psen_lvl), .o_rise(w_psen_rise), .o_fall(w_psen_fall)
  );
  sync_edge #(.INIT(STB_INACTIVE)) u_sync_wr (
    .clk_50(clk_50), .reset(reset), .i_async(bus.mcu_wr_n),
    .o_level(w_wr_lvl), .o_rise(w_wr_rise), .o_fall(w_wr_fall)
  );
  sync_edge #(.INIT(STB_INACTIVE)) u_sync_rd (
    .clk_50(clk_50), .reset(reset), .i_async(bus.mcu_rd_n),
    .o_level(w_rd_lvl), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
  );

  assign w_unused_edges = w_ale_rise ^ w_psen_rise ^ w_psen_fall ^ w_rd_rise;

  // Data buses: same 2-flop depth as the strobes, plus a third stage that
  // lines up with the ALE delay flop so the address is the last ALE=1 sample.
  logic [DATA_W-1:0] r_p0_s1, r_p0_s2, r_p0_s3;
  logic [DATA_W-1:0] r_p2_s1, r_p2_s2, r_p2_s3;

  // P0/P2 synchroniser and alignment stages.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_p0_s1 <= DATA_INACTIVE;
      r_p0_s2 <= DATA_INACTIVE;
      r_p0_s3 <= DATA_INACTIVE;
      r_p2_s1 <= DATA_INACTIVE;
      r_p2_s2 <= DATA_INACTIVE;
      r_p2_s3 <= DATA_INACTIVE;
    end else begin
      r_p0_s1 <= bus.mcu_p0_i;
      r_p0_s2 <= r_p0_s1;
      r_p0_s3 <= r_p0_s2;
      r_p2_s1 <= bus.mcu_p2_i;
      r_p2_s2 <= r_p2_s1;
      r_p2_s3 <= r_p2_s2;
    end
  end

  logic [ADDR_W-1:0] r_addr;

  // Address latch, updated only on synced ALE fall.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_addr <= 16'h0000;
    end else if (w_ale_fall) begin
      r_addr <= {r_p2_s3, r_p0_s3};
    end else begin
      r_addr <= r_addr;
    end
  end

  // WR/RD falls only count outside the address phase and outside code fetches.
  logic w_bus_ok;
  logic w_wr_start;
  logic w_rd_start;
  assign w_bus_ok   = ~w_ale_lvl & w_psen_lvl;
  assign w_wr_start = w_wr_fall & w_bus_ok;
  assign w_rd_start = w_rd_fall & w_bus_ok;

  bus_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_wr_stb, w_wr_stb_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_rd_pend, w_rd_pend_nxt;
  logic              r_rd_stb;
  logic              r_err, w_err_nxt;
  logic              r_p0_oe, w_p0_oe_nxt;
  logic [DATA_W-1:0] r_p0_o, w_p0_o_nxt;

  // Read-strobe delay line; the tap at RD_LAT marks the cycle bus_rdata is valid.
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [RD_LAT:0]   w_rd_line;
  logic              w_rd_load;
  assign w_rd_line = {r_rd_pipe, r_rd_stb};
  assign w_rd_load = w_rd_line[RD_LAT];

  // FSM state and all registered outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_wr_stb  <= 1'b0;
      r_wdata   <= 8'h00;
      r_rd_pend <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_rd_pipe <= '0;
      r_err     <= 1'b0;
      r_p0_oe   <= 1'b0;
      r_p0_o    <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_stb  <= w_wr_stb_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_rd_stb  <= r_rd_pend;
      r_rd_pipe <= w_rd_line[RD_LAT-1:0];
      r_err     <= w_err_nxt;
      r_p0_oe   <= w_p0_oe_nxt;
      r_p0_o    <= w_p0_o_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_stb_nxt  = 1'b0;
    w_wdata_nxt   = r_wdata;
    w_rd_pend_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_p0_oe_nxt   = r_p0_oe;
    w_p0_o_nxt    = r_p0_o;
    case (r_state)
      ST_IDLE: begin
        w_p0_oe_nxt = 1'b0;
        if (w_wr_start && w_rd_start) begin
          w_err_nxt = 1'b1;
        end else if (w_wr_start) begin
          w_state_nxt = ST_WR_WAIT;
          w_cnt_nxt   = 4'd0;
        end else if (w_rd_start) begin
          w_state_nxt   = ST_RD_ACT;
          w_rd_pend_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        // An early WR_n release means the data window never opened.
        if (w_wr_rise) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(WR_SAMPLE_DLY - 1)) begin
          w_err_nxt    = w_rd_start;
          w_wr_stb_nxt = 1'b1;
          w_wdata_nxt  = r_p0_s2;
          w_state_nxt  = ST_WR_HOLD;
        end else begin
          w_err_nxt = w_rd_start;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_WR_HOLD: begin
        w_err_nxt = w_rd_start;
        if (w_wr_lvl) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_HOLD;
        end
      end
      ST_RD_ACT: begin
        w_err_nxt = w_wr_start;
        if (w_rd_lvl) begin
          w_state_nxt = ST_IDLE;
          w_p0_oe_nxt = 1'b0;
        end else if (w_rd_load) begin
          w_p0_o_nxt  = bus.bus_rdata;
          w_p0_oe_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RD_ACT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_p0_oe_nxt = 1'b0;
      end
    endcase
  end

  assign bus.bus_addr   = r_addr;
  assign bus.bus_wdata  = r_wdata;
  assign bus.bus_wr_stb = r_wr_stb;
  assign bus.bus_rd_stb = r_rd_stb;
  assign bus.bus_err    = r_err;
  assign bus.mcu_p0_o   = r_p0_o;
  assign bus.mcu_p0_oe  = r_p0_oe;

endmodule

// File: tb/tb_mcu_bus_if.sv
// tb_mcu_bus_if: scoreboard bench for mcu_bus_if (WR_SAMPLE_DLY=8, RD_LAT=1).
// Stimulus tasks push expected writes/reads/errors into queues; a monitor pops
// and compares them whenever the DUT raises a strobe or bus_err.
module tb_mcu_bus_if;
  import max51_bus_pkg::*;

  logic clk_50 = 1'b0;
  logic reset;

  mcu_bus_if_if u_bus ();

  mcu_bus_if #(.WR_SAMPLE_DLY(8), .RD_LAT(1)) dut (
    .clk_50(clk_50),
    .reset (reset),
    .bus   (u_bus)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];
  bit          err_q[$];
  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int rd_seen  = 0;
  int err_seen = 0;

  // Scoreboard monitor: every strobe/err must match a queued expectation.
  initial begin
    wr_exp_t     e;
    logic [15:0] ra;
    forever begin
      @(negedge clk_50);
      if (u_bus.bus_wr_stb === 1'b1) begin
        wr_seen++;
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%h data=%h", u_bus.bus_addr, u_bus.bus_wdata);
        end else begin
          e = wr_q.pop_front();
          if ({u_bus.bus_addr, u_bus.bus_wdata} !== {e.addr, e.data}) begin
            failures++;
            $display("FAIL wr_data got addr=%h data=%h want addr=%h data=%h",
                     u_bus.bus_addr, u_bus.bus_wdata, e.addr, e.data);
          end
        end
      end
      if (u_bus.bus_rd_stb === 1'b1) begin
        rd_seen++;
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected addr=%h", u_bus.bus_addr);
        end else begin
          ra = rd_q.pop_front();
          if (u_bus.bus_addr !== ra) begin
            failures++;
            $display("FAIL rd_addr got=%h want=%h", u_bus.bus_addr, ra);
          end
        end
      end
      if (u_bus.bus_err === 1'b1) begin
        err_seen++;
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL err_unexpected got=1 want=0");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  // Time bound on the whole run.
  initial begin
    #200us;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // ALE address phase; optional WR_n glitch while ALE is high.
  task automatic latch_addr(input logic [15:0] a, input bit wr_glitch);
    @(posedge clk_50);
    #3;
    u_bus.mcu_p2_i = a[15:8];
    u_bus.mcu_p0_i = a[7:0];
    u_bus.mcu_ale  = 1'b1;
    if (wr_glitch) begin
      #40 u_bus.mcu_wr_n = 1'b0;
      #60 u_bus.mcu_wr_n = 1'b1;
      #100;
    end else begin
      #200;
    end
    u_bus.mcu_ale = 1'b0;
    #30 u_bus.mcu_p0_i = 8'hFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_50);
    #1;
    checks++;
    if (u_bus.bus_addr !== 16'h0000) begin
      failures++; $display("FAIL reset_addr got=%h want=0000", u_bus.bus_addr);
    end
    checks++;
    if ({u_bus.bus_wr_stb, u_bus.bus_rd_stb, u_bus.bus_err} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b want=000",
                           {u_bus.bus_wr_stb, u_bus.bus_rd_stb, u_bus.bus_err});
    end
    checks++;
    if ({u_bus.mcu_p0_oe, u_bus.mcu_p0_o, u_bus.bus_wdata} !== 17'h00000) begin
      failures++; $display("FAIL reset_p0 got oe=%b p0=%h wdata=%h want 0",
                           u_bus.mcu_p0_oe, u_bus.mcu_p0_o, u_bus.bus_wdata);
    end
    @(negedge clk_50);
    reset = 1'b0;
    repeat (4) @(posedge clk_50);
  endtask

  task automatic test_addr_latch(input logic [15:0] a);
    int w0;
    w0 = wr_seen + rd_seen;
    latch_addr(a, 1'b0);
    repeat (4) @(posedge clk_50);
    #1;
    checks++;
    if (u_bus.bus_addr !== a) begin
      failures++; $display("FAIL addr_latch got=%h want=%h", u_bus.bus_addr, a);
    end
    checks++;
    if (wr_seen + rd_seen !== w0) begin
      failures++; $display("FAIL addr_no_strobe got=%0d want=%0d", wr_seen + rd_seen, w0);
    end
  endtask

  task automatic test_write(input logic [15:0] a, input logic [7:0] d, input bit rd_intrude);
    int lat;
    int w0;
    lat = -1;
    latch_addr(a, 1'b0);
    repeat (3) @(posedge clk_50);
    w0 = wr_seen;
    wr_q.push_back('{addr: a, data: d});
    if (rd_intrude) err_q.push_back(1'b1);
    @(posedge clk_50);
    #2;
    u_bus.mcu_wr_n = 1'b0;
    fork
      begin
        #50  u_bus.mcu_p0_i = d;
        #200 u_bus.mcu_p0_i = 8'hFF;
        #50  u_bus.mcu_wr_n = 1'b1;
      end
      begin
        if (rd_intrude) begin
          #100 u_bus.mcu_rd_n = 1'b0;
          #60  u_bus.mcu_rd_n = 1'b1;
        end
      end
      begin
        for (int i = 1; i <= 30; i++) begin
          @(posedge clk_50);
          #1;
          if (u_bus.bus_wr_stb === 1'b1 && lat < 0) lat = i;
        end
      end
    join
    checks++;
    if (lat !== 11) begin
      failures++; $display("FAIL wr_latency got=%0d want=11", lat);
    end
    checks++;
    if (wr_seen - w0 !== 1 || wr_q.size() !== 0) begin
      failures++; $display("FAIL wr_count got=%0d want=1", wr_seen - w0);
    end
    checks++;
    if (err_q.size() !== 0) begin
      failures++; $display("FAIL wr_err_pending got=%0d want=0", err_q.size());
    end
  endtask

  task automatic test_wr_abort();
    int w0;
    w0 = wr_seen;
    err_q.push_back(1'b1);
    @(posedge clk_50);
    #2;
    u_bus.mcu_wr_n = 1'b0;
    #60 u_bus.mcu_wr_n = 1'b1;
    repeat (14) @(posedge clk_50);
    checks++;
    if (err_q.size() !== 0) begin
      failures++; $display("FAIL abort_err got_missing=%0d want=0", err_q.size());
    end
    checks++;
    if (wr_seen !== w0) begin
      failures++; $display("FAIL abort_no_strobe got=%0d want=%0d", wr_seen, w0);
    end
  endtask

  task automatic test_read(input logic [15:0] a, input logic [7:0] d);
    int lat;
    lat = -1;
    latch_addr(a, 1'b0);
    repeat (3) @(posedge clk_50);
    u_bus.bus_rdata = d;
    rd_q.push_back(a);
    @(posedge clk_50);
    #2;
    u_bus.mcu_rd_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_50);
      #1;
      if (u_bus.bus_rd_stb === 1'b1 && lat < 0) lat = i;
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL rd_latency got=%0d want=4", lat);
    end
    checks++;
    if ({u_bus.mcu_p0_oe, u_bus.mcu_p0_o} !== {1'b1, d}) begin
      failures++; $display("FAIL rd_drive got oe=%b p0=%h want oe=1 p0=%h",
                           u_bus.mcu_p0_oe, u_bus.mcu_p0_o, d);
    end
    @(posedge clk_50);
    #2;
    u_bus.mcu_rd_n = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    checks++;
    if (u_bus.mcu_p0_oe !== 1'b1) begin
      failures++; $display("FAIL rd_oe_hold got=%b want=1", u_bus.mcu_p0_oe);
    end
    @(posedge clk_50);
    #1;
    checks++;
    if (u_bus.mcu_p0_oe !== 1'b0) begin
      failures++; $display("FAIL rd_oe_release got=%b want=0", u_bus.mcu_p0_oe);
    end
    checks++;
    if (rd_q.size() !== 0) begin
      failures++; $display("FAIL rd_count got_missing=%0d want=0", rd_q.size());
    end
  endtask

  task automatic test_code_fetch(input logic [15:0] a);
    int s0;
    s0 = wr_seen + rd_seen + err_seen;
    u_bus.mcu_psen_n = 1'b0;
    latch_addr(a, 1'b1);
    repeat (4) @(posedge clk_50);
    #1;
    checks++;
    if (u_bus.bus_addr !== a) begin
      failures++; $display("FAIL fetch_addr got=%h want=%h", u_bus.bus_addr, a);
    end
    u_bus.mcu_psen_n = 1'b1;
    repeat (6) @(posedge clk_50);
    checks++;
    if (wr_seen + rd_seen + err_seen !== s0) begin
      failures++; $display("FAIL fetch_no_strobe got=%0d want=%0d", wr_seen + rd_seen + err_seen, s0);
    end
  endtask

  task automatic test_conflict();
    int s0;
    s0 = wr_seen + rd_seen;
    err_q.push_back(1'b1);
    @(posedge clk_50);
    #2;
    u_bus.mcu_wr_n = 1'b0;
    u_bus.mcu_rd_n = 1'b0;
    #100;
    u_bus.mcu_wr_n = 1'b1;
    u_bus.mcu_rd_n = 1'b1;
    repeat (8) @(posedge clk_50);
    checks++;
    if (err_q.size() !== 0 || wr_seen + rd_seen !== s0) begin
      failures++; $display("FAIL conflict got err_missing=%0d strobes=%0d want 0 0",
                           err_q.size(), wr_seen + rd_seen - s0);
    end
  endtask

  task automatic test_reset_mid_read();
    bit got_oe;
    got_oe = 1'b0;
    latch_addr(16'h2222, 1'b0);
    repeat (3) @(posedge clk_50);
    u_bus.bus_rdata = 8'h3C;
    rd_q.push_back(16'h2222);
    @(posedge clk_50);
    #2;
    u_bus.mcu_rd_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_50);
      #1;
      if (u_bus.mcu_p0_oe === 1'b1) got_oe = 1'b1;
    end
    checks++;
    if (got_oe !== 1'b1) begin
      failures++; $display("FAIL rst_read_oe got=0 want=1");
    end
    @(posedge clk_50);
    #2;
    reset = 1'b1;
    @(posedge clk_50);
    #1;
    checks++;
    if ({u_bus.mcu_p0_oe, u_bus.bus_addr} !== 17'h00000) begin
      failures++; $display("FAIL rst_mid_read got oe=%b addr=%h want 0",
                           u_bus.mcu_p0_oe, u_bus.bus_addr);
    end
    u_bus.mcu_rd_n = 1'b1;
    repeat (3) @(posedge clk_50);
    #2;
    reset = 1'b0;
    repeat (4) @(posedge clk_50);
    test_write(16'h0A0B, 8'h77, 1'b0);
  endtask

  // Test sequence.
  initial begin
    u_bus.mcu_ale    = 1'b0;
    u_bus.mcu_psen_n = 1'b1;
    u_bus.mcu_wr_n   = 1'b1;
    u_bus.mcu_rd_n   = 1'b1;
    u_bus.mcu_p0_i   = 8'hFF;
    u_bus.mcu_p2_i   = 8'h00;
    u_bus.bus_rdata  = 8'h00;
    reset            = 1'b1;
    test_reset();
    test_addr_latch(16'h5555);
    test_write(16'h5555, 8'h01, 1'b0);
    test_wr_abort();
    test_read(16'h1234, 8'hA5);
    test_code_fetch(16'hBEEF);
    test_conflict();
    test_write(16'hC3A0, 8'h5A, 1'b1);
    test_reset_mid_read();
    repeat (4) @(posedge clk_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
